conv3x3_stream: RTL and testbench
=================================

// Module: conv3x3_stream
// PURPOSE
//  Streaming 3x3 convolution datapath downstream of the AXI-Lite control block.
//  Consumes start/run/filter_weights from it. Filters one AXI-Stream grayscale frame per start ("valid" mode, no padding).
//  Returns frame_done, which drives the controller's tlast input so its STATUS register moves RUN->DONE.
// PARAMETERS
//  IMG_W  64  input frame width in pixels (>=3)
//  IMG_H  64  input frame height in lines (>=3)
//  PIX_W  8   pixel width, unsigned
// PORTS
//  clk             in   1      single clock
//  rst             in   1      synchronous, active-high reset
//  start           in   1      1-cycle pulse from controller: begin frame
//  run             in   1      controller RUN level; low while busy = abort
//  filter_weights  in   27     9 taps x 3b signed, row-major, tap0 (top-left)=[2:0], tap8=[26:24]
//  s_axis_tdata    in   PIX_W  input pixel, raster order
//  s_axis_tvalid   in   1      input valid
//  s_axis_tready   out  1      input ready
//  s_axis_tlast    in   1      end-of-frame marker, checked only
//  m_axis_tdata    out  PIX_W  filtered pixel
//  m_axis_tvalid   out  1      output valid
//  m_axis_tready   in   1      output ready
//  m_axis_tlast    out  1      high with last output pixel of frame
//  frame_done      out  1      1-cycle pulse after last output handshake -> controller tlast
//  frame_err       out  1      sticky: s_axis_tlast misplaced; cleared by start
// BEHAVIOUR
//  Reset: all outputs 0, FSM IDLE, pipeline valids 0, counters 0.
//  FSM: IDLE -start-> RUN. RUN -(IMG_W*IMG_H pixels accepted)-> DRAIN. DRAIN -(last output handshake)-> IDLE with frame_done=1.
//   start outside IDLE ignored. run low in RUN/DRAIN: abort next cycle.
//   Abort -> IDLE, all stage valids cleared, no frame_done.
//  Weights latched on start; filter_weights changes mid-frame have no effect.
//  Flow control: adv = !m_axis_tvalid | m_axis_tready. All stages move only on adv.
//   s_axis_tready = (state==RUN) & run & adv.
//  Pipeline (handshake at edge t): line buffers + 3x3 window update at t.
//   Signed sum registered at t+1. Clamped result in m_axis_tdata/tvalid at t+2, given adv throughout.
//  Window valid when accepted pixel (r,c) has r>=2 and c>=2. Output frame (IMG_W-2)x(IMG_H-2), raster order.
//   m_axis_tlast on output from pixel (IMG_H-1, IMG_W-1).
//  Column counter wraps IMG_W-1->0 and increments row. Row counter stops at IMG_H-1. Window columns never span a line wrap.
//  Arithmetic: pixel zero-extended to PIX_W+1 x signed 3b (-4..3) -> 9-term signed sum, SUM_W=PIX_W+7 bits.
//   Clamp: <0 -> 0, >2^PIX_W-1 -> 2^PIX_W-1. No shift or scale.
//  frame_err set if s_axis_tlast=1 on a non-final pixel or 0 on the final pixel. Framing is by counters only.
//  m_axis_tdata/tlast held stable while m_axis_tvalid & !m_axis_tready (AXIS rule).
//  Backpressure never drops or duplicates pixels. Line buffers write only on input handshake.
// STRUCTURE
//  conv_pkg: FSM state localparams (IDLE/RUN/DRAIN), TAPS=9, COEF_W=3, SUM_W, clamp function.
//  Sub-module line_buffer: IMG_W-deep x PIX_W circular delay line with enable.
//   Two instances give rows r-1 and r-2.
//  Top holds window regs, MAC + clamp stages, counters, FSM.
// TESTING (IMG_W=IMG_H=4, input ramp 0..15, m_axis_tready=1 unless noted)
//  Identity, weights=27'h0001000 -> outputs 5,6,9,10; tlast with 10; frame_done 1 cycle after; frame_err=0.
//  Box, weights=27'h1249249 -> outputs 45,54,81,90; all taps 1, no clamping.
//  Saturation: all pixels 255, weights=27'h36DB6DB (all 3) -> four 255s. weights=27'h7FFFFFF (all -1) -> four 0s.
//  Backpressure: m_axis_tready toggles 1010..., s_axis_tvalid random -> identical output sequence to identity case.
//   Data stable during stall.
//  Abort: run low after 9 input pixels -> IDLE next cycle, m_axis_tvalid=0, no frame_done.
//   Next start processes a full frame correctly.
//  Framing: s_axis_tlast on pixel 7 -> frame_err=1, output unchanged. start clears frame_err.

Source files
------------

// File: rtl/conv_pkg.sv
// Shared types, constants and the output clamp for the 3x3 streaming convolution.
package conv_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2
   } state_t;

   localparam int TAPS       = 9;
   localparam int COEF_W     = 3;
   localparam int SUM_GROWTH = 7;

   function automatic int sum_w(input int pix_w);
      return pix_w + SUM_GROWTH;
   endfunction

   // Saturate a signed sum into the unsigned pixel range [0, 2^pix_w-1].
   function automatic logic [31:0] clamp_pix(input logic signed [31:0] s, input int pix_w);
      logic signed [31:0] max_v;
      max_v = (32'sd1 <<< pix_w) - 32'sd1;
      if (s < 0)
         return '0;
      else if (s > max_v)
         return $unsigned(max_v);
      return $unsigned(s);
   endfunction

endpackage

// File: rtl/line_buffer.sv
// Circular delay line: dout is the value written DEPTH enabled writes ago.
module line_buffer #(
   parameter int DEPTH = 64,
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PW-1:0]    ptr_q, ptr_d;

   always_comb begin
      ptr_d = ptr_q;
      if (en)
         ptr_d = (ptr_q == PW'(DEPTH - 1)) ? '0 : ptr_q + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst)
         ptr_q <= '0;
      else
         ptr_q <= ptr_d;
   end

   always_ff @(posedge clk) begin
      if (en)
         mem_q[ptr_q] <= din;
   end

   assign dout = mem_q[ptr_q];

endmodule

// File: rtl/conv3x3_stream.sv
// Streaming 3x3 "valid" convolution: window regs, MAC, clamp, frame counters and sequencing FSM.
module conv3x3_stream
   import conv_pkg::*;
#(
   parameter int IMG_W = 64,
   parameter int IMG_H = 64,
   parameter int PIX_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             run,
   input  logic [26:0]      filter_weights,
   input  logic [PIX_W-1:0] s_axis_tdata,
   input  logic             s_axis_tvalid,
   output logic             s_axis_tready,
   input  logic             s_axis_tlast,
   output logic [PIX_W-1:0] m_axis_tdata,
   output logic             m_axis_tvalid,
   input  logic             m_axis_tready,
   output logic             m_axis_tlast,
   output logic             frame_done,
   output logic             frame_err
);

   localparam int SUM_W = sum_w(PIX_W);
   localparam int CW    = (IMG_W > 1) ? $clog2(IMG_W) : 1;
   localparam int RW    = (IMG_H > 1) ? $clog2(IMG_H) : 1;

   state_t                   state_q, state_d;
   logic [26:0]              weights_q, weights_d;
   logic [CW-1:0]            col_q, col_d;
   logic [RW-1:0]            row_q, row_d;
   logic [PIX_W-1:0]         win_q [TAPS];
   logic [PIX_W-1:0]         win_d [TAPS];
   logic                     win_vld_q, win_vld_d, win_last_q, win_last_d;
   logic signed [SUM_W-1:0]  sum_q, sum_d;
   logic                     sum_vld_q, sum_vld_d, sum_last_q, sum_last_d;
   logic [PIX_W-1:0]         m_tdata_q, m_tdata_d;
   logic                     m_tvalid_q, m_tvalid_d, m_tlast_q, m_tlast_d;
   logic                     frame_done_q, frame_done_d;
   logic                     frame_err_q, frame_err_d;

   logic [PIX_W-1:0]         row1_pix, row2_pix;
   logic signed [SUM_W-1:0]  mac_sum, pix_s, coef_s;
   logic                     adv, in_hs, last_pix, out_last_hs, abort, start_ok;

   assign adv           = !m_tvalid_q || m_axis_tready;
   assign s_axis_tready = (state_q == ST_RUN) && run && adv;
   assign in_hs         = s_axis_tready && s_axis_tvalid;
   assign last_pix      = (row_q == RW'(IMG_H - 1)) && (col_q == CW'(IMG_W - 1));
   assign out_last_hs   = m_tvalid_q && m_axis_tready && m_tlast_q;
   assign abort         = (state_q != ST_IDLE) && !run;
   assign start_ok      = (state_q == ST_IDLE) && start;

   // Cascaded delay lines give the same column one and two lines back.
   line_buffer #(.DEPTH(IMG_W), .WIDTH(PIX_W)) u_lb_r1 (
      .clk  (clk),
      .rst  (rst),
      .en   (in_hs),
      .din  (s_axis_tdata),
      .dout (row1_pix)
   );

   line_buffer #(.DEPTH(IMG_W), .WIDTH(PIX_W)) u_lb_r2 (
      .clk  (clk),
      .rst  (rst),
      .en   (in_hs),
      .din  (row1_pix),
      .dout (row2_pix)
   );

   always_comb begin
      state_d      = state_q;
      frame_done_d = 1'b0;
      case (state_q)
         ST_IDLE:  if (start) state_d = ST_RUN;
         ST_RUN: begin
            if (abort)
               state_d = ST_IDLE;
            else if (in_hs && last_pix)
               state_d = ST_DRAIN;
         end
         ST_DRAIN: begin
            if (abort)
               state_d = ST_IDLE;
            else if (out_last_hs) begin
               state_d      = ST_IDLE;
               frame_done_d = 1'b1;
            end
         end
         default:  state_d = ST_IDLE;
      endcase
   end

   // Window index = row*3 + col; row 0 is two lines back, col 2 is newest.
   always_comb begin
      mac_sum = '0;
      pix_s   = '0;
      coef_s  = '0;
      for (int i = 0; i < TAPS; i++) begin
         pix_s   = SUM_W'(win_q[i]);
         coef_s  = SUM_W'($signed(weights_q[i*COEF_W +: COEF_W]));
         mac_sum = mac_sum + pix_s * coef_s;
      end
   end

   always_comb begin
      weights_d   = weights_q;
      col_d       = col_q;
      row_d       = row_q;
      frame_err_d = frame_err_q;
      win_d       = win_q;
      win_vld_d   = win_vld_q;
      win_last_d  = win_last_q;
      sum_d       = sum_q;
      sum_vld_d   = sum_vld_q;
      sum_last_d  = sum_last_q;
      m_tdata_d   = m_tdata_q;
      m_tvalid_d  = m_tvalid_q;
      m_tlast_d   = m_tlast_q;

      if (start_ok) begin
         weights_d   = filter_weights;
         col_d       = '0;
         row_d       = '0;
         frame_err_d = 1'b0;
      end else if (in_hs) begin
         if (s_axis_tlast != last_pix)
            frame_err_d = 1'b1;
         if (col_q == CW'(IMG_W - 1)) begin
            col_d = '0;
            if (row_q != RW'(IMG_H - 1))
               row_d = row_q + 1'b1;
         end else begin
            col_d = col_q + 1'b1;
         end
      end

      if (in_hs) begin
         for (int r = 0; r < 3; r++) begin
            win_d[r*3]     = win_q[r*3 + 1];
            win_d[r*3 + 1] = win_q[r*3 + 2];
         end
         win_d[2] = row2_pix;
         win_d[5] = row1_pix;
         win_d[8] = s_axis_tdata;
      end

      if (adv) begin
         win_vld_d  = in_hs && (row_q >= RW'(2)) && (col_q >= CW'(2));
         win_last_d = in_hs && last_pix;
         sum_d      = mac_sum;
         sum_vld_d  = win_vld_q;
         sum_last_d = win_last_q;
         m_tdata_d  = PIX_W'(clamp_pix(32'(sum_q), PIX_W));
         m_tvalid_d = sum_vld_q;
         m_tlast_d  = sum_last_q;
      end

      if (abort || start_ok) begin
         win_vld_d  = 1'b0;
         win_last_d = 1'b0;
         sum_vld_d  = 1'b0;
         sum_last_d = 1'b0;
         m_tvalid_d = 1'b0;
         m_tlast_d  = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         weights_q    <= '0;
         col_q        <= '0;
         row_q        <= '0;
         win_q        <= '{default: '0};
         win_vld_q    <= 1'b0;
         win_last_q   <= 1'b0;
         sum_q        <= '0;
         sum_vld_q    <= 1'b0;
         sum_last_q   <= 1'b0;
         m_tdata_q    <= '0;
         m_tvalid_q   <= 1'b0;
         m_tlast_q    <= 1'b0;
         frame_done_q <= 1'b0;
         frame_err_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         weights_q    <= weights_d;
         col_q        <= col_d;
         row_q        <= row_d;
         win_q        <= win_d;
         win_vld_q    <= win_vld_d;
         win_last_q   <= win_last_d;
         sum_q        <= sum_d;
         sum_vld_q    <= sum_vld_d;
         sum_last_q   <= sum_last_d;
         m_tdata_q    <= m_tdata_d;
         m_tvalid_q   <= m_tvalid_d;
         m_tlast_q    <= m_tlast_d;
         frame_done_q <= frame_done_d;
         frame_err_q  <= frame_err_d;
      end
   end

   assign m_axis_tdata  = m_tdata_q;
   assign m_axis_tvalid = m_tvalid_q;
   assign m_axis_tlast  = m_tlast_q;
   assign frame_done    = frame_done_q;
   assign frame_err     = frame_err_q;

endmodule

// File: tb/tb_conv3x3_stream.sv
// Directed bench for conv3x3_stream on a 4x4 frame, checked against a direct convolution model.
module tb_conv3x3_stream;

   localparam int W  = 4;
   localparam int H  = 4;
   localparam int PW = 8;
   localparam int NO = (W - 2) * (H - 2);

   logic          clk = 1'b0;
   logic          rst, start, run;
   logic [26:0]   filter_weights;
   logic [PW-1:0] s_axis_tdata, m_axis_tdata;
   logic          s_axis_tvalid, s_axis_tready, s_axis_tlast;
   logic          m_axis_tvalid, m_axis_tready, m_axis_tlast;
   logic          frame_done, frame_err;

   always #5 clk = ~clk;

   conv3x3_stream #(.IMG_W(W), .IMG_H(H), .PIX_W(PW)) dut (
      .clk            (clk),
      .rst            (rst),
      .start          (start),
      .run            (run),
      .filter_weights (filter_weights),
      .s_axis_tdata   (s_axis_tdata),
      .s_axis_tvalid  (s_axis_tvalid),
      .s_axis_tready  (s_axis_tready),
      .s_axis_tlast   (s_axis_tlast),
      .m_axis_tdata   (m_axis_tdata),
      .m_axis_tvalid  (m_axis_tvalid),
      .m_axis_tready  (m_axis_tready),
      .m_axis_tlast   (m_axis_tlast),
      .frame_done     (frame_done),
      .frame_err      (frame_err)
   );

   int        errors = 0;
   int        checks = 0;
   int        frame_pix [W*H];
   int        model_out [NO];
   int        exp_q [$];
   bit        expl_q [$];
   bit        bp_mode = 1'b0;
   bit        done_seen = 1'b0;
   bit        exp_done_next = 1'b0;
   bit        prev_stall = 1'b0;
   logic [PW-1:0] prev_data;
   logic      prev_last;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Direct 3x3 valid convolution with per-pixel clamp.
   function automatic void model(input logic [26:0] w);
      for (int r = 1; r < H - 1; r++) begin
         for (int c = 1; c < W - 1; c++) begin
            int s;
            s = 0;
            for (int k = 0; k < 9; k++) begin
               logic [2:0] t;
               int cf;
               t  = w[k*3 +: 3];
               cf = t[2] ? int'(t) - 8 : int'(t);
               s += frame_pix[(r - 1 + k / 3) * W + (c - 1 + k % 3)] * cf;
            end
            if (s < 0) s = 0;
            if (s > 255) s = 255;
            model_out[(r - 1) * (W - 2) + (c - 1)] = s;
         end
      end
   endfunction

   task automatic pin_model(input string name, input int e0, input int e1, input int e2, input int e3);
      check({name, "_0"}, model_out[0], e0);
      check({name, "_1"}, model_out[1], e1);
      check({name, "_2"}, model_out[2], e2);
      check({name, "_3"}, model_out[3], e3);
   endtask

   initial begin
      forever begin
         @(posedge clk);
         #1;
         m_axis_tready = bp_mode ? ~m_axis_tready : 1'b1;
      end
   end

   // Output monitor: every handshake, every stall cycle and every frame_done pulse.
   initial begin
      forever begin
         @(negedge clk);
         if (rst) begin
            prev_stall    = 1'b0;
            exp_done_next = 1'b0;
         end else begin
            if (exp_done_next || frame_done) begin
               check("frame_done_timing", frame_done, exp_done_next);
               if (frame_done) done_seen = 1'b1;
            end
            exp_done_next = 1'b0;
            if (prev_stall) begin
               check("stall_valid", m_axis_tvalid, 1);
               check("stall_data", m_axis_tdata, prev_data);
               check("stall_last", m_axis_tlast, prev_last);
            end
            if (m_axis_tvalid && m_axis_tready) begin
               if (exp_q.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected_output: got %0d expected none", m_axis_tdata);
               end else begin
                  int ed;
                  bit el;
                  ed = exp_q.pop_front();
                  el = expl_q.pop_front();
                  check("out_data", m_axis_tdata, ed);
                  check("out_last", m_axis_tlast, el);
                  if (el) exp_done_next = 1'b1;
               end
            end
            prev_stall = m_axis_tvalid && !m_axis_tready;
            prev_data  = m_axis_tdata;
            prev_last  = m_axis_tlast;
         end
      end
   end

   task automatic do_start(input logic [26:0] w);
      @(posedge clk);
      #1;
      filter_weights = w;
      start = 1'b1;
      run   = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      filter_weights = ~w;
      check("err_cleared_by_start", frame_err, 0);
   endtask

   task automatic feed(input int tlast_idx, input bit rand_valid, input int abort_after);
      int  idx;
      int  cyc;
      bit  hs;
      idx = 0;
      cyc = 0;
      while (idx < W * H) begin
         if (abort_after >= 0 && idx == abort_after) break;
         s_axis_tvalid = rand_valid ? ($urandom_range(0, 3) != 0) : 1'b1;
         s_axis_tdata  = PW'(frame_pix[idx]);
         s_axis_tlast  = (idx == tlast_idx);
         @(negedge clk);
         hs = s_axis_tvalid && s_axis_tready;
         @(posedge clk);
         #1;
         if (hs) idx++;
         cyc++;
         if (cyc > 2000) begin
            check("input_timeout", idx, W * H);
            break;
         end
      end
      s_axis_tvalid = 1'b0;
      s_axis_tlast  = 1'b0;
   endtask

   task automatic run_frame(input logic [26:0] w, input int tlast_idx, input bit rand_valid, input bit bp);
      int cyc;
      model(w);
      for (int i = 0; i < NO; i++) begin
         exp_q.push_back(model_out[i]);
         expl_q.push_back(i == NO - 1);
      end
      done_seen = 1'b0;
      do_start(w);
      bp_mode = bp;
      feed(tlast_idx, rand_valid, -1);
      cyc = 0;
      while (!done_seen && cyc < 300) begin
         @(posedge clk);
         #1;
         cyc++;
      end
      bp_mode = 1'b0;
      check("frame_done_seen", done_seen, 1);
      check("outputs_drained", exp_q.size(), 0);
      check("frame_err_end", frame_err, (tlast_idx != W * H - 1));
      exp_q.delete();
      expl_q.delete();
   endtask

   initial begin
      rst = 1'b1;
      start = 1'b0;
      run = 1'b0;
      filter_weights = '0;
      s_axis_tdata = '0;
      s_axis_tvalid = 1'b0;
      s_axis_tlast = 1'b0;
      m_axis_tready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("rst_m_tvalid", m_axis_tvalid, 0);
      check("rst_m_tdata", m_axis_tdata, 0);
      check("rst_m_tlast", m_axis_tlast, 0);
      check("rst_s_tready", s_axis_tready, 0);
      check("rst_frame_done", frame_done, 0);
      check("rst_frame_err", frame_err, 0);
      rst = 1'b0;

      for (int i = 0; i < W * H; i++) frame_pix[i] = i;
      model(27'h0001000);
      pin_model("model_identity", 5, 6, 9, 10);
      run_frame(27'h0001000, W * H - 1, 1'b0, 1'b0);

      model(27'h1249249);
      pin_model("model_box", 45, 54, 81, 90);
      run_frame(27'h1249249, W * H - 1, 1'b0, 1'b0);

      for (int i = 0; i < W * H; i++) frame_pix[i] = 255;
      model(27'h36DB6DB);
      pin_model("model_sat_hi", 255, 255, 255, 255);
      run_frame(27'h36DB6DB, W * H - 1, 1'b0, 1'b0);
      model(27'h7FFFFFF);
      pin_model("model_sat_lo", 0, 0, 0, 0);
      run_frame(27'h7FFFFFF, W * H - 1, 1'b0, 1'b0);

      for (int i = 0; i < W * H; i++) frame_pix[i] = i;
      run_frame(27'h0001000, W * H - 1, 1'b1, 1'b1);

      done_seen = 1'b0;
      do_start(27'h0001000);
      feed(W * H - 1, 1'b0, 9);
      run = 1'b0;
      @(posedge clk);
      #1;
      run = 1'b1;
      @(negedge clk);
      check("abort_m_tvalid", m_axis_tvalid, 0);
      check("abort_idle_tready", s_axis_tready, 0);
      repeat (10) @(posedge clk);
      #1;
      check("abort_no_done", done_seen, 0);
      check("abort_idle_still", s_axis_tready, 0);

      run_frame(27'h0001000, W * H - 1, 1'b0, 1'b0);
      run_frame(27'h0001000, 7, 1'b0, 1'b0);
      run_frame(27'h1249249, W * H - 1, 1'b0, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule
